// File: rtl/uat_pkg.sv
// Shared link definitions for the 162-bit one-wire packet link (transmitter and receiver).
// Holds the FSM state encoding, the bit timing constants and a small helper function.
package uat_pkg;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        GUARD = 5'b00010,
        START = 5'b00100,
        DATA  = 5'b01000,
        STOP  = 5'b10000
    } state_e;

    localparam int LINK_CLK_PER_SAMP  = 423;
    localparam int LINK_SAMP_PER_BIT  = 16;
    localparam int LINK_CLK_PER_BIT   = LINK_CLK_PER_SAMP * LINK_SAMP_PER_BIT;
    localparam int LINK_PKT_LNGTH     = 162;
    localparam int LINK_RX_ARM_CYCLES = 1300000;
    // The guard has to outlast the receiver's arming count so every frame re-arms it.
    localparam int LINK_GUARD_CYCLES  = 1400000;
    localparam int LINK_STOP_BITS     = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uat_bit_timer.sv
// Loadable down-counter: a load of N produces a one-cycle done pulse N cycles later.
// The load strobe takes priority, so a reload on the done cycle restarts the interval seamlessly.
module uat_bit_timer #(
    parameter int CNT_W = 21
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] load_val_in,
    output logic             done_out
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_in) begin
            cnt_d = load_val_in - CNT_W'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_out = run_q && (cnt_q == '0);

endmodule

// File: rtl/uat_fsm.sv
// Serial packet transmitter: guard interval, low start bit, PKT_LNGTH data bits LSB-first, stop bit.
// sig_out and ready are both flops so the line never glitches and has no path from the inputs.
module uat_fsm
    import uat_pkg::*;
#(
    parameter int CLK_PER_BIT  = LINK_CLK_PER_BIT,
    parameter int PKT_LNGTH    = LINK_PKT_LNGTH,
    parameter int GUARD_CYCLES = LINK_GUARD_CYCLES,
    parameter int STOP_BITS    = LINK_STOP_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [PKT_LNGTH-1:0] data_in,
    output logic                 sig_out,
    output logic                 ready
);

    localparam int STOP_CYCLES = STOP_BITS * CLK_PER_BIT;
    localparam int CNT_W       = $clog2(max_int(GUARD_CYCLES, STOP_CYCLES)) + 1;
    localparam int BIT_W       = $clog2(PKT_LNGTH) + 1;

    state_e               state_q, state_d;
    logic [PKT_LNGTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 sig_q, sig_d;
    logic                 ready_q, ready_d;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_done;

    uat_bit_timer #(
        .CNT_W(CNT_W)
    ) u_bit_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_in    (tmr_load),
        .load_val_in(tmr_val),
        .done_out   (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        sig_d     = sig_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state_q)
            IDLE: begin
                sig_d = 1'b1;
                if (start_in) begin
                    state_d  = GUARD;
                    shreg_d  = data_in;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GUARD_CYCLES);
                end
            end
            GUARD: begin
                sig_d = 1'b1;
                if (tmr_done) begin
                    state_d  = START;
                    sig_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(CLK_PER_BIT);
                end
            end
            START: begin
                sig_d = 1'b0;
                if (tmr_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    sig_d     = shreg_q[0];
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(CLK_PER_BIT);
                end
            end
            DATA: begin
                // The next bit is taken from shreg_q[1] so it appears on the same edge as the shift.
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (bit_cnt_q == BIT_W'(PKT_LNGTH - 1)) begin
                        state_d = STOP;
                        sig_d   = 1'b1;
                        tmr_val = CNT_W'(STOP_CYCLES);
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        sig_d     = shreg_q[1];
                        tmr_val   = CNT_W'(CLK_PER_BIT);
                    end
                end
            end
            STOP: begin
                sig_d = 1'b1;
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = 1'b1;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sig_q     <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sig_q     <= sig_d;
            ready_q   <= ready_d;
        end
    end

    assign sig_out = sig_q;
    assign ready   = ready_q;

endmodule
